// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: pointer sizing and
// parameter legality predicates used at elaboration.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately never reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = ptr_w(DEPTH) - 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, registered threshold flags, sticky
// overflow/underflow and an optional first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wren,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rden,
  output logic [DATA_W-1:0]        rdata,
  output logic                     wfull,
  output logic                     rempty,
  output logic                     walmost_full,
  output logic                     ralmost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] ONE     = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_T    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T    = PW'(AE_THRESH);

  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be at least 1");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two, at least 2");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_param: AF_THRESH or AE_THRESH out of range");
  end

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_count;
  logic [PW-1:0]     w_count_nxt;
  logic              r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic              w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0] w_mem_rdata;

  // A write into a full FIFO still goes through when a read frees a slot.
  assign w_rd_acc    = rden & ~r_empty;
  assign w_wr_acc    = wren & (~r_full | w_rd_acc);
  assign w_count_nxt = r_count + {{(PW-1){1'b0}}, w_wr_acc} - {{(PW-1){1'b0}}, w_rd_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= AF_T);
      r_ae    <= (w_count_nxt <= AE_T);
      // Setting beats clearing so an error in the clearing cycle is not lost.
      if (wren & ~w_wr_acc) r_ovf <= 1'b1;
      else if (clr_err)     r_ovf <= 1'b0;
      if (rden & ~w_rd_acc) r_unf <= 1'b1;
      else if (clr_err)     r_unf <= 1'b0;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign rdata = w_mem_rdata;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] r_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_rdata <= '0;
      else if (w_rd_acc) r_rdata <= w_mem_rdata;
    end
    assign rdata = r_rdata;
  end

  assign count         = r_count;
  assign wfull         = r_full;
  assign rempty        = r_empty;
  assign walmost_full  = r_af;
  assign ralmost_empty = r_ae;
  assign overflow      = r_ovf;
  assign underflow     = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read instance checked against a
// queue model and a vector table, plus a first-word-fall-through instance.
module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wren = 1'b0, rden = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0]    count;

  logic          f_wren = 1'b0, f_rden = 1'b0, f_clr = 1'b0;
  logic [DW-1:0] f_wdata = '0;
  logic [DW-1:0] f_rdata;
  logic          f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]    f_count;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wdata(wdata), .rden(rden),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wren(f_wren), .wdata(f_wdata), .rden(f_rden),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .walmost_full(f_af),
    .ralmost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf), .clr_err(f_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rdata = '0;
  bit            m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    bit            w;
    logic [DW-1:0] d;
    bit            r;
    bit            c;
    int            cnt;
    bit            full, empty, af, ae, ovf, unf;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock of the registered-read instance; model predicts, scoreboard checks.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit mr, mw;
    int n;
    wren = w; wdata = d; rden = r; clr_err = c;
    mr = r && (m_q.size() != 0);
    mw = w && ((m_q.size() < DEPTH) || mr);
    if (mr) exp_q.push_back(m_q.pop_front());
    if (mw) m_q.push_back(d);
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (w && !mw) m_ovf = 1'b1;
    if (r && !mr) m_unf = 1'b1;
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    if (exp_q.size() != 0) m_rdata = exp_q.pop_front();
    n = m_q.size();
    chk({phase, ".rdata"},  rdata,         m_rdata);
    chk({phase, ".count"},  count,         n);
    chk({phase, ".wfull"},  wfull,         n == DEPTH);
    chk({phase, ".rempty"}, rempty,        n == 0);
    chk({phase, ".afull"},  walmost_full,  n >= DEPTH - 2);
    chk({phase, ".aempty"}, ralmost_empty, n <= 2);
    chk({phase, ".ovf"},    overflow,      m_ovf);
    chk({phase, ".unf"},    underflow,     m_unf);
  endtask

  task automatic fcycle(input bit w, input logic [DW-1:0] d, input bit r);
    f_wren = w; f_wdata = d; f_rden = r;
    @(posedge clk); #1;
    f_wren = 1'b0; f_rden = 1'b0;
  endtask

  initial begin
    //          w  d         r  c  cnt full empty af ae ovf unf rdata
    tbl[0]  = '{1, 32'hA0,   0, 0, 1,  0,   0,    0, 1, 0,  0,  32'h0};
    tbl[1]  = '{1, 32'hA1,   0, 0, 2,  0,   0,    0, 1, 0,  0,  32'h0};
    tbl[2]  = '{1, 32'hA2,   0, 0, 3,  0,   0,    0, 0, 0,  0,  32'h0};
    tbl[3]  = '{0, 32'h0,    1, 0, 2,  0,   0,    0, 1, 0,  0,  32'hA0};
    tbl[4]  = '{1, 32'hA3,   1, 0, 2,  0,   0,    0, 1, 0,  0,  32'hA1};
    tbl[5]  = '{0, 32'h0,    1, 0, 1,  0,   0,    0, 1, 0,  0,  32'hA2};
    tbl[6]  = '{0, 32'h0,    1, 0, 0,  0,   1,    0, 1, 0,  0,  32'hA3};
    tbl[7]  = '{0, 32'h0,    1, 0, 0,  0,   1,    0, 1, 0,  1,  32'hA3};
    tbl[8]  = '{0, 32'h0,    0, 1, 0,  0,   1,    0, 1, 0,  0,  32'hA3};
    tbl[9]  = '{1, 32'hA4,   1, 0, 1,  0,   0,    0, 1, 0,  1,  32'hA3};
    tbl[10] = '{0, 32'h0,    1, 1, 0,  0,   1,    0, 1, 0,  0,  32'hA4};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    chk("reset.count",  count,         0);
    chk("reset.rempty", rempty,        1);
    chk("reset.wfull",  wfull,         0);
    chk("reset.aempty", ralmost_empty, 1);
    chk("reset.afull",  walmost_full,  0);
    chk("reset.ovf",    overflow,      0);
    chk("reset.unf",    underflow,     0);
    chk("reset.rdata",  rdata,         0);
    chk("reset.f_rempty", f_rempty,    1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    phase = "table";
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("v%0d.count", i),  count,         tbl[i].cnt);
      chk($sformatf("v%0d.wfull", i),  wfull,         tbl[i].full);
      chk($sformatf("v%0d.rempty", i), rempty,        tbl[i].empty);
      chk($sformatf("v%0d.afull", i),  walmost_full,  tbl[i].af);
      chk($sformatf("v%0d.aempty", i), ralmost_empty, tbl[i].ae);
      chk($sformatf("v%0d.ovf", i),    overflow,      tbl[i].ovf);
      chk($sformatf("v%0d.unf", i),    underflow,     tbl[i].unf);
      chk($sformatf("v%0d.rdata", i),  rdata,         tbl[i].rd);
    end

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    chk("fill.full16", wfull, 1);
    phase = "overflow";
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("overflow.set", overflow, 1);
    phase = "clr_vs_set";
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b1);
    chk("clr_vs_set.ovf", overflow, 1);
    phase = "clr_alone";
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_alone.ovf", overflow, 0);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain.last", rdata, 32'hF);
    phase = "underflow";
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("underflow.hold", rdata, 32'hF);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    phase = "wrap";
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h100 + DW'(k * 10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("wrap.last", rdata, 32'h113);

    phase = "simul_full";
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hAA, 1'b1, 1'b0);
    chk("simul_full.rdata", rdata, 32'h0);
    chk("simul_full.count", count, 16);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("simul_full.lastAA", rdata, 32'hAA);
    phase = "simul_empty";
    cycle(1'b1, 32'h77, 1'b1, 1'b0);
    chk("simul_empty.unf", underflow, 1);
    chk("simul_empty.count", count, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);

    phase = "rst_mid";
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
    chk("rst_mid.count7", count, 7);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.count",  count,  0);
    chk("rst_mid.rempty", rempty, 1);
    chk("rst_mid.aempty", ralmost_empty, 1);
    chk("rst_mid.rdata",  rdata,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    phase = "post_rst";
    cycle(1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_rst.rdata", rdata, 32'h300);

    phase = "fwft";
    chk("fwft.empty0", f_rempty, 1);
    fcycle(1'b1, 32'h55, 1'b0);
    chk("fwft.rempty", f_rempty, 0);
    chk("fwft.rdata",  f_rdata,  32'h55);
    fcycle(1'b0, 32'h0, 1'b0);
    chk("fwft.hold",   f_rdata,  32'h55);
    fcycle(1'b0, 32'h0, 1'b1);
    chk("fwft.pop_empty", f_rempty, 1);
    chk("fwft.pop_count", f_count,  0);
    fcycle(1'b1, 32'h66, 1'b0);
    fcycle(1'b1, 32'h77, 1'b0);
    chk("fwft.head66", f_rdata, 32'h66);
    chk("fwft.count2", f_count, 2);
    fcycle(1'b0, 32'h0, 1'b1);
    chk("fwft.head77", f_rdata, 32'h77);
    fcycle(1'b0, 32'h0, 1'b1);
    chk("fwft.empty",  f_rempty, 1);
    fcycle(1'b0, 32'h0, 1'b1);
    chk("fwft.unf",    f_unf, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the dual-clock FIFO: same write/read port naming, but generic in data width and depth. Adds programmable almost-full/almost-empty thresholds, a fill count, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. Used as the general buffering element between same-clock pipeline stages.

## Interface
- DATA_W, 32, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, walmost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, ralmost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  input  1  single clock, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- wren  input  1  write request
- wdata  input  DATA_W  write data
- rden  input  1  read request
- rdata  output  DATA_W  read data
- wfull  output  1  FIFO holds DEPTH words
- rempty  output  1  FIFO holds 0 words
- walmost_full  output  1  count ≥ AF_THRESH
- ralmost_empty  output  1  count ≤ AE_THRESH
- count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH
- overflow  output  1  sticky: write rejected
- underflow  output  1  sticky: read rejected
- clr_err  input  1  clears overflow/underflow

## Operation
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; low bits address memory, MSB is wrap bit; natural modulo-2^(ADDR_W+1) increment, no explicit wrap logic.
- Write accepted (wr_acc) = wren & (!wfull | rd_acc). Read accepted (rd_acc) = rden & !rempty.
- Full + wren + rden: both accepted, count unchanged, oldest word out, new word in.
- Empty + wren + rden: write accepted, read rejected (underflow set), count becomes 1.
- count next = count + wr_acc − rd_acc; wfull, rempty, walmost_full, ralmost_empty all registered, computed from next count, so they are consistent with count every cycle.
- FWFT=0: on rd_acc, rdata ← mem[rd_ptr] at that edge; otherwise rdata holds its previous value.
- FWFT=1: rdata = mem[rd_ptr] combinationally whenever !rempty; rd_acc pops; rdata undefined-but-stable (holds last array content) when rempty.
- overflow ← 1 on wren & !wr_acc; underflow ← 1 on rden & !rd_acc; clr_err clears both; set wins over clear in same cycle.
- Memory contents are not reset; rejected writes do not modify memory.

## Timing
- Reset values: count 0, rempty 1, wfull 0, ralmost_empty 1, walmost_full 0 (AF_THRESH ≥ 1), overflow 0, underflow 0, rdata 0 (FWFT=0), pointers 0.
- Reset asserted mid-operation: immediate flush; all state above returns to reset values asynchronously; first write after release lands at address 0.
- Write latency: word written at edge N is readable from edge N+1 (rempty low after N; FWFT rdata valid after N).
- FWFT=0 read latency: rden accepted at edge N → rdata valid after edge N, held until next rd_acc.
- Flag update: every flag changes on the same edge as the count change causing it; no lag cycle.

## Structure
- Package fifo_pkg: function for pointer width ($clog2(DEPTH)+1), parameter legality checks (power-of-two DEPTH, threshold ranges) as elaboration-time assertions.
- Sub-module sync_fifo_mem: DEPTH×DATA_W register array, one write port, one asynchronous read port; top level adds the FWFT=0 output register.
- Top level holds pointers, counter, flags and error logic.

## Test plan
- Reset then fill (DEPTH=16): 16 writes 0x0..0xF → count 16, wfull 1, walmost_full from count 14; 17th write → rejected, overflow 1, memory unchanged.
- Drain full FIFO, FWFT=0: 16 reads → rdata 0x0..0xF one edge after each rden; rempty 1 after 16th; 17th read → underflow 1, rdata stays 0xF.
- Wrap-around: 10 writes, 10 reads, 10 writes, 10 reads, data 0x100+i → in-order output, count never exceeds 10, pointers cross address 15→0.
- Simultaneous at full: full with 0x0..0xF, wren+rden with 0xAA → rdata 0x0, count 16, last word read out later is 0xAA; at empty, wren+rden → underflow 1, count 1.
- FWFT=1: write 0x55 into empty → after that edge rempty 0, rdata 0x55 without rden; rden pops → rempty 1.
- Errors/reset: set overflow, assert clr_err with simultaneous rejected write → overflow stays 1; clr_err alone → 0; assert rst_n low mid-burst at count 7 → count 0, rempty 1 immediately, no clk edge needed.
